// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle 32-bit integer divider for DIV / DIVU requests from the EX
//   stage. EX raises start_i with its operands and stalls; the unit returns
//   {remainder, quotient} on result_o together with ready_o. EX forwards the
//   remainder as the HI write and the quotient as the LO write.
//   Radix-2 restoring division, one quotient bit per clock.
//
// Parameters
//   WIDTH         operand width (result_o is 2*WIDTH)
//   CNT_W         iteration counter width, must be able to hold WIDTH
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     dividend, sampled only when a request is accepted
//   opdata2_i     divisor, sampled only when a request is accepted
//   start_i       request, held high by EX until it has consumed the result
//   annul_i       cancels an in-flight division (pipeline flush)
//   result_o      {remainder, quotient}, valid while ready_o = 1
//   ready_o       result valid
//   div_zero_o    divisor was zero (present only with DIV_ZERO_FLAG_EN)
//
// Build option
//   DIV_ZERO_FLAG_EN  when defined, adds the div_zero_o port. When it is not
//                     defined a divide-by-zero simply returns 0 with ready_o.
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div_zero_o
`endif
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // rem holds the partial remainder. quo starts as the dividend magnitude;
  // each step shifts its MSB into rem and a quotient bit into its LSB, so
  // after WIDTH steps it holds the full quotient magnitude.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic             dvd_neg;
  logic             dsr_neg;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic             accept_neg1;
  logic             accept_neg2;

  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes at accept time. For DIVU the operands pass through.
  always_comb begin
    accept_neg1 = signed_div_i & opdata1_i[WIDTH-1];
    accept_neg2 = signed_div_i & opdata2_i[WIDTH-1];
    dvd_mag     = accept_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    dsr_mag     = accept_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor. The extra top bit of trial
  // is the borrow; a borrow means the subtraction is discarded.
  always_comb begin
    trial  = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dsr};
    borrow = trial[WIDTH+1];
  end

  // Sign fixup. Negation wraps mod 2^WIDTH, so the most negative dividend
  // divided by -1 gives back the most negative value as quotient.
  always_comb begin
    quo_fix = (dvd_neg ^ dsr_neg) ? (~quo + 1'b1) : quo;
    rem_fix = dvd_neg ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      dvd_neg  <= 1'b0;
      dsr_neg  <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_o <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_o <= 1'b0;
`endif
          if (start_i && !annul_i) begin
            dvd_neg <= accept_neg1;
            dsr_neg <= accept_neg2;
            dsr     <= dsr_mag;
            quo     <= dvd_mag;
            rem     <= '0;
            cnt     <= '0;
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
            end
          end
        end

        // Divide-by-zero waits one padding edge (cnt 0 -> 1) so the zero
        // result is presented two edges after the request was accepted.
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            cnt <= CNT_W'(1);
          end else begin
            state    <= END;
            cnt      <= '0;
            ready_o  <= 1'b1;
            result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b1;
`endif
          end
        end

        ON: begin
          if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt == CNT_W'(WIDTH)) begin
            state    <= END;
            cnt      <= '0;
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quo_fix};
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (borrow) begin
              rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
          end
        end

        // The result stays on the outputs until EX drops start_i; a flush
        // arriving here is ignored because the result is already complete.
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
          end
        end

        default: begin
          state    <= FREE;
          cnt      <= '0;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. The driver issues directed requests
//   and pushes the hand-computed result, latency and zero flag into a
//   scoreboard queue; the monitor pops an entry each time ready_o rises and
//   checks the result stays stable while ready_o is held.
// ---------------------------------------------------------------------------
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int checks;
  int failures;
  int cycle;

  typedef struct {
    string       name;
    logic [63:0] result;
    int          lat;
    logic        zero;
    int          e0;
  } exp_t;

  exp_t sb[$];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o   (div_zero)
`endif
  );

  // Free-running clock and an edge counter used to measure latency.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one request, keep start held until the result has been seen for
  // a few cycles, then release it and confirm the unit returns to idle.
  task automatic applyStimulus(input string name, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp_result,
                               input int exp_lat, input logic exp_zero);
    exp_t e;
    exp_t dropped;
    bit   got;
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    e.name   = name;
    e.result = exp_result;
    e.lat    = exp_lat;
    e.zero   = exp_zero;
    e.e0     = cycle + 1;
    sb.push_back(e);
    @(negedge clk);
    // Operands are garbage after acceptance; the unit must ignore them.
    opdata1 = 32'hDEAD_BEEF;
    opdata2 = 32'h0000_0001;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      if (ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checkOutput({name, " timeout"}, 64'd0, 64'd1);
      if (sb.size() > 0) dropped = sb.pop_front();
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput({name, " ready after drop"}, 64'(ready), 64'd0);
    checkOutput({name, " result after drop"}, result, 64'd0);
  endtask

  // Monitor: pops the scoreboard on each rising ready and checks the held
  // result while ready stays high.
  initial begin : monitor
    logic        prev_ready;
    logic [63:0] cur;
    exp_t        e;
    prev_ready = 1'b0;
    cur        = '0;
    forever begin
      @(negedge clk);
      if (ready && !prev_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected ready", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, " result"}, result, e.result);
          checkOutput({e.name, " latency"}, 64'(cycle - e.e0), 64'(e.lat));
`ifdef DIV_ZERO_FLAG_EN
          checkOutput({e.name, " div_zero"}, 64'(div_zero), 64'(e.zero));
`endif
          cur = e.result;
        end
      end else if (ready && prev_ready) begin
        checkOutput("result stable", result, cur);
      end
      prev_ready = ready;
    end
  end

  initial begin : driver
    bit saw;
    cycle      = 0;
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 64'(ready), 64'd0);
    checkOutput("reset result", result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("reset div_zero", 64'(div_zero), 64'd0);
`endif
    rst = 1'b0;

    applyStimulus("u100/7",        1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 33, 1'b0);
    applyStimulus("s-7/2",         1'b1, 32'hFFFFFFF9,  32'h2,        64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    applyStimulus("s min/-1",      1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
    applyStimulus("u5/0",          1'b0, 32'd5,         32'd0,        64'h00000000_00000000,  2, 1'b1);
    applyStimulus("s-9/0",         1'b1, 32'hFFFFFFF7,  32'd0,        64'h00000000_00000000,  2, 1'b1);
    applyStimulus("u max/1",       1'b0, 32'hFFFFFFFF,  32'd1,        64'h00000000_FFFFFFFF, 33, 1'b0);
    applyStimulus("u max/max",     1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001, 33, 1'b0);
    applyStimulus("s7/-2",         1'b1, 32'd7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    applyStimulus("u3/10",         1'b0, 32'd3,         32'd10,       64'h00000003_00000000, 33, 1'b0);
    applyStimulus("s-100/-7",      1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 1'b0);
    applyStimulus("u 0x8../max",   1'b0, 32'h80000000,  32'hFFFFFFFF, 64'h80000000_00000000, 33, 1'b0);
    applyStimulus("u 12345678/1000", 1'b0, 32'h12345678, 32'h1000,    64'h00000678_00012345, 33, 1'b0);

    // Flush at cnt=10: no result may appear, then a fresh request works.
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd7;
    start      = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    saw   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      annul = 1'b0;
      if (ready) saw = 1'b1;
    end
    checkOutput("annul no ready", 64'(saw), 64'd0);
    applyStimulus("u9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);

    // Reset at cnt=20 drops the operation.
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'hFFFFFFFF;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (21) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("mid reset ready", 64'(ready), 64'd0);
    checkOutput("mid reset result", result, 64'd0);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    checkOutput("reset drop no ready", 64'(saw), 64'd0);
    applyStimulus("u1000/10 after reset", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
